bitfield_exec_unit: RTL and testbench

//   Pipelined bitfield-move functional unit for the Tomasulo backend: executes UBFM, SBFM and BFM
//   (insert) on a 32- or 64-bit operand, carrying the destination tag alongside the data.

---
 rtl/bitfield_exec_unit_pkg.sv | 43 ++++
 rtl/bitfield_mask_gen.sv | 42 ++++
 rtl/bitfield_exec_unit.sv | 134 +++++++++++++
 tb/tb_bitfield_exec_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitfield_exec_unit_pkg.sv
// Package for the bitfield-move execution unit.
//   bfm_op_t    : operation select (unsigned extract, signed extract, insert)
//   bfm_req_t   : one issued operation as it travels down the pipeline
//   bfm_stage_t : pipeline stage payload (request plus precomputed masks)
//   bfm_amt     : reduces an immr/imms field to the operand width (mod 32 or 64)
//   bfm_dmask   : all-ones over the active operand width
package bitfield_exec_unit_pkg;

  localparam int BFM_XLEN  = 64;
  localparam int BFM_TAG_W = 6;

  typedef enum logic [1:0] {
    BFM_U   = 2'd0,
    BFM_S   = 2'd1,
    BFM_INS = 2'd2
  } bfm_op_t;

  typedef struct packed {
    bfm_op_t                op;
    logic                   sf;
    logic [5:0]             immr;
    logic [5:0]             imms;
    logic [BFM_XLEN-1:0]    src;
    logic [BFM_XLEN-1:0]    dst;
    logic [BFM_TAG_W-1:0]   tag;
  } bfm_req_t;

  typedef struct packed {
    bfm_req_t            req;
    logic [BFM_XLEN-1:0] wmask;
    logic [BFM_XLEN-1:0] tmask;
  } bfm_stage_t;

  // In 32-bit mode bit 5 of the immediate is ignored, giving mod-32.
  function automatic logic [5:0] bfm_amt(input logic sf, input logic [5:0] amt);
    return sf ? amt : {1'b0, amt[4:0]};
  endfunction

  function automatic logic [BFM_XLEN-1:0] bfm_dmask(input logic sf);
    return sf ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

endpackage

// File: rtl/bitfield_mask_gen.sv
// Combinational mask generator for bitfield moves.
//   sf    in  1   1 = 64-bit operand, 0 = 32-bit operand
//   immr  in  6   rotate amount
//   imms  in  6   field top bit
//   wmask out 64  ones over the placed field [p+w-1:p]
//   tmask out 64  ones from the field base p up to the top of the operand;
//                 tmask & ~wmask is the sign-fill region above the field
module bitfield_mask_gen
  import bitfield_exec_unit_pkg::*;
(
  input  logic        sf,
  input  logic [5:0]  immr,
  input  logic [5:0]  imms,
  output logic [63:0] wmask,
  output logic [63:0] tmask
);

  logic [6:0] r;
  logic [6:0] s;
  logic [6:0] d;
  logic [6:0] w;
  logic [6:0] p;

  always_comb begin
    r = {1'b0, bfm_amt(sf, immr)};
    s = {1'b0, bfm_amt(sf, imms)};
    d = sf ? 7'd64 : 7'd32;
    if (s >= r) begin
      // Extract: field starts at src bit r and lands at bit 0.
      w = s - r + 7'd1;
      p = 7'd0;
    end else begin
      // Deposit: low w bits of src land at bit d-r (r >= 1 here, so p <= 63).
      w = s + 7'd1;
      p = d - r;
    end
    // A shift by 64 yields zero, so w = 64 produces an all-ones field.
    wmask = (~({64{1'b1}} << w)) << p;
    tmask = bfm_dmask(sf) & ({64{1'b1}} << p);
  end

endmodule

// File: rtl/bitfield_exec_unit.sv
// Pipelined bitfield-move functional unit (UBFM / SBFM / BFM insert).
//   in_clk, in_rst_n     clock, asynchronous active-low reset
//   in_flush             squash every in-flight op, including one issuing now
//   in_valid/out_ready   issue handshake from the reservation station
//   in_op, in_sf         operation and width (1 = 64-bit)
//   in_immr, in_imms     rotate amount and field top bit
//   in_src, in_dst       source operand and old destination (insert only)
//   in_tag               destination tag, carried with the data
//   out_valid/in_cdb_ready  result handshake towards the CDB arbiter
//   out_value, out_tag   result and its tag
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. The whole pipeline advances together when adv = !out_valid | in_cdb_ready;
// out_ready equals adv, so an issue is accepted exactly when the pipe moves.
// While out_valid=1 and in_cdb_ready=0 every stage holds, so out_value/out_tag
// stay stable. Flush clears all valid bits on the next edge regardless of adv.
//
// Stage 0 registers the operands with their masks; the last stage rotates,
// masks, sign-fills and merges combinationally from its register.
module bitfield_exec_unit
  import bitfield_exec_unit_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_flush,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [1:0]       in_op,
  input  logic             in_sf,
  input  logic [5:0]       in_immr,
  input  logic [5:0]       in_imms,
  input  logic [XLEN-1:0]  in_src,
  input  logic [XLEN-1:0]  in_dst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             in_cdb_ready,
  output logic [XLEN-1:0]  out_value,
  output logic [TAG_W-1:0] out_tag
);

  logic       adv;
  logic       stage_valid [STAGES];
  bfm_stage_t stage_q     [STAGES];
  bfm_stage_t stage_in;
  logic [63:0] wmask_in;
  logic [63:0] tmask_in;

  assign adv       = !out_valid || in_cdb_ready;
  assign out_ready = adv;
  assign out_valid = stage_valid[STAGES-1];

  bitfield_mask_gen u_mask_gen (
    .sf    (in_sf),
    .immr  (in_immr),
    .imms  (in_imms),
    .wmask (wmask_in),
    .tmask (tmask_in)
  );

  always_comb begin
    stage_in          = '0;
    stage_in.req.op   = bfm_op_t'(in_op);
    stage_in.req.sf   = in_sf;
    stage_in.req.immr = in_immr;
    stage_in.req.imms = in_imms;
    stage_in.req.src  = in_src;
    stage_in.req.dst  = in_dst;
    stage_in.req.tag  = BFM_TAG_W'(in_tag);
    stage_in.wmask    = wmask_in;
    stage_in.tmask    = tmask_in;
  end

  // Payload shifts only with adv; flush overrides the valid shift.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_valid[i] <= 1'b0;
        stage_q[i]     <= '0;
      end
    end else begin
      if (adv) begin
        stage_valid[0] <= in_valid;
        stage_q[0]     <= stage_in;
        for (int i = 1; i < STAGES; i++) begin
          stage_valid[i] <= stage_valid[i-1];
          stage_q[i]     <= stage_q[i-1];
        end
      end
      if (in_flush) begin
        for (int i = 0; i < STAGES; i++) begin
          stage_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Final stage: rotate right by r within the operand width, then merge.
  bfm_stage_t  last;
  logic [5:0]  r;
  logic [5:0]  s;
  logic [63:0] rot64;
  logic [31:0] rot32;
  logic [63:0] rot;
  logic [63:0] field;
  logic        sign;
  logic [63:0] result;

  assign last = stage_q[STAGES-1];

  always_comb begin
    r      = bfm_amt(last.req.sf, last.req.immr);
    s      = bfm_amt(last.req.sf, last.req.imms);
    rot64  = (last.req.src >> r) | (last.req.src << (7'd64 - {1'b0, r}));
    rot32  = (last.req.src[31:0] >> r) | (last.req.src[31:0] << (7'd32 - {1'b0, r}));
    rot    = last.req.sf ? rot64 : {32'b0, rot32};
    field  = rot & last.wmask;
    // In both extract and deposit forms the field MSB is source bit s.
    sign   = last.req.src[s];
    result = field;
    case (last.req.op)
      BFM_S:   result = field | (sign ? (last.tmask & ~last.wmask) : 64'd0);
      BFM_INS: result = field | (last.req.dst & bfm_dmask(last.req.sf) & ~last.wmask);
      default: result = field;
    endcase
  end

  assign out_value = XLEN'(result);
  assign out_tag   = TAG_W'(last.req.tag);

endmodule

// File: tb/tb_bitfield_exec_unit.sv
// Self-checking bench for bitfield_exec_unit: directed cases followed by
// randomized traffic with backpressure, flushes and an asynchronous reset.
module tb_bitfield_exec_unit;

  localparam int STAGES = 2;
  localparam int TAG_W  = 6;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready;
  logic [1:0]       in_op = 2'd0;
  logic             in_sf = 1'b0;
  logic [5:0]       in_immr = 6'd0;
  logic [5:0]       in_imms = 6'd0;
  logic [63:0]      in_src = 64'd0;
  logic [63:0]      in_dst = 64'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             in_cdb_ready = 1'b0;
  logic [63:0]      out_value;
  logic [TAG_W-1:0] out_tag;

  bitfield_exec_unit #(.XLEN(64), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .in_clk       (clk),
    .in_rst_n     (rst_n),
    .in_flush     (in_flush),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .in_op        (in_op),
    .in_sf        (in_sf),
    .in_immr      (in_immr),
    .in_imms      (in_imms),
    .in_src       (in_src),
    .in_dst       (in_dst),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .in_cdb_ready (in_cdb_ready),
    .out_value    (out_value),
    .out_tag      (out_tag)
  );

  // Scoreboard
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc = 0;
  int stall_cnt = 0;
  logic [69:0] exp_q[$];
  int          iss_q[$];
  int          stl_q[$];
  logic        prev_stall = 1'b0;
  logic        after_flush = 1'b0;
  logic [63:0] prev_val = '0;
  logic [TAG_W-1:0] prev_tag = '0;

  // Next-cycle drive values
  logic        d_valid = 1'b0;
  logic [1:0]  d_op = 2'd0;
  logic        d_sf = 1'b0;
  logic [5:0]  d_immr = 6'd0;
  logic [5:0]  d_imms = 6'd0;
  logic [63:0] d_src = '0;
  logic [63:0] d_dst = '0;
  logic [TAG_W-1:0] d_tag = '0;
  logic        d_cdb = 1'b1;
  logic        d_flush = 1'b0;
  logic [63:0] d_exp = '0;

  // Reference model: built bit by bit from the field placement rules.
  function automatic logic [63:0] ref_bfm(input logic [1:0] op, input logic sf,
                                          input logic [5:0] immr, input logic [5:0] imms,
                                          input logic [63:0] src, input logic [63:0] dst);
    int d;
    int r;
    int s;
    int w;
    int p;
    int base;
    logic sign;
    logic [63:0] res;
    d = sf ? 64 : 32;
    r = int'(immr) % d;
    s = int'(imms) % d;
    if (s >= r) begin
      w = s - r + 1; p = 0; base = r;
    end else begin
      w = s + 1; p = d - r; base = 0;
    end
    sign = src[base + w - 1];
    res = '0;
    for (int i = 0; i < d; i++) begin
      if (i >= p && i < p + w) res[i] = src[base + i - p];
      else if (i >= p + w)     res[i] = (op == 2'd1) ? sign : (op == 2'd2) ? dst[i] : 1'b0;
      else                     res[i] = (op == 2'd2) ? dst[i] : 1'b0;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Driver: present d_* for one cycle, check outputs, update the scoreboard.
  task automatic tick();
    logic ov;
    logic exp_ready;
    logic [69:0] e;
    int iss;
    int stl;
    in_valid = d_valid; in_op = d_op; in_sf = d_sf; in_immr = d_immr; in_imms = d_imms;
    in_src = d_src; in_dst = d_dst; in_tag = d_tag; in_cdb_ready = d_cdb; in_flush = d_flush;
    #1;
    ov = out_valid;
    exp_ready = !ov || d_cdb;
    check("out_ready", 64'(out_ready), 64'(exp_ready));
    if (after_flush) check("flush_clear", 64'(ov), 64'd0);
    if (prev_stall) begin
      check("stall_valid", 64'(ov), 64'd1);
      check("stall_value", out_value, prev_val);
      check("stall_tag", 64'(out_tag), 64'(prev_tag));
    end
    if (ov) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(ov), 64'd0);
      end else if (d_cdb && !d_flush) begin
        e = exp_q.pop_front();
        iss = iss_q.pop_front();
        stl = stl_q.pop_front();
        check("value", out_value, e[63:0]);
        check("tag", 64'(out_tag), 64'(e[69:64]));
        check("latency", 64'(cyc - iss), 64'(STAGES + stall_cnt - stl));
      end
    end
    prev_stall = ov && !d_cdb && !d_flush;
    prev_val = out_value;
    prev_tag = out_tag;
    if (prev_stall) stall_cnt++;
    after_flush = d_flush;
    if (d_flush) begin
      exp_q.delete(); iss_q.delete(); stl_q.delete();
    end else if (d_valid && exp_ready) begin
      exp_q.push_back({d_tag, d_exp});
      iss_q.push_back(cyc);
      stl_q.push_back(stall_cnt);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_op(input logic [1:0] op, input logic sf, input logic [5:0] immr,
                        input logic [5:0] imms, input logic [63:0] src, input logic [63:0] dst,
                        input logic [TAG_W-1:0] tag, input logic [63:0] exp);
    d_valid = 1'b1; d_op = op; d_sf = sf; d_immr = immr; d_imms = imms;
    d_src = src; d_dst = dst; d_tag = tag; d_exp = exp;
  endtask

  task automatic set_rand_op();
    logic [1:0] op;
    logic sf;
    logic [5:0] immr;
    logic [5:0] imms;
    logic [63:0] src;
    logic [63:0] dst;
    op = 2'($urandom_range(0, 2));
    sf = 1'($urandom_range(0, 1));
    immr = 6'($urandom_range(0, 63));
    imms = 6'($urandom_range(0, 63));
    src = {$urandom, $urandom};
    dst = {$urandom, $urandom};
    set_op(op, sf, immr, imms, src, dst, TAG_W'($urandom_range(0, 63)),
           ref_bfm(op, sf, immr, imms, src, dst));
  endtask

  task automatic set_idle();
    d_valid = 1'b0;
    d_flush = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_value", out_value, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, issued back to back
    d_cdb = 1'b1;
    set_op(2'd0, 1'b1, 6'd8, 6'd15, 64'h1234_5678_9ABC_DEF0, 64'd0, 6'h01, 64'hDE);
    tick();
    set_op(2'd1, 1'b1, 6'd4, 6'd7, 64'hF0, 64'd0, 6'h02, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    set_op(2'd1, 1'b1, 6'd4, 6'd7, 64'h70, 64'd0, 6'h03, 64'h7);
    tick();
    set_op(2'd0, 1'b0, 6'd28, 6'd27, 64'hFFFF_FFFF_8000_000F, 64'd0, 6'h04, 64'hF0);
    tick();
    set_op(2'd2, 1'b1, 6'd60, 6'd3, 64'hA, 64'hFFFF_FFFF_FFFF_FFFF, 6'h05, 64'hFFFF_FFFF_FFFF_FFAF);
    tick();
    set_op(2'd1, 1'b0, 6'd0, 6'd7, 64'hFFFF_0000_0000_0080, 64'd0, 6'h06, 64'h0000_0000_FFFF_FF80);
    tick();
    set_idle();
    repeat (4) tick();

    // Backpressure: 4 ops streamed, CDB stalls 3 cycles
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_rand_op(); else set_idle();
      d_cdb = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      tick();
    end
    d_cdb = 1'b1;
    set_idle();
    repeat (4) tick();

    // Flush with every stage occupied plus one op issuing, output stalled
    set_rand_op(); tick();
    set_rand_op(); tick();
    set_rand_op(); d_flush = 1'b1; d_cdb = 1'b0; tick();
    set_idle(); d_cdb = 1'b1;
    repeat (5) tick();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) set_rand_op(); else d_valid = 1'b0;
      d_flush = ($urandom_range(0, 49) == 0);
      d_cdb = d_flush ? 1'b0 : ($urandom_range(0, 9) < 7);
      tick();
    end

    // Asynchronous reset mid-stream
    d_flush = 1'b0;
    d_cdb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand_op();
      d_cdb = (i == 0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_value", out_value, 64'd0);
    check("async_rst_tag", 64'(out_tag), 64'd0);
    exp_q.delete(); iss_q.delete(); stl_q.delete();
    prev_stall = 1'b0;
    after_flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    d_cdb = 1'b1;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 9) < 8) set_rand_op(); else d_valid = 1'b0;
      d_cdb = ($urandom_range(0, 9) < 6);
      tick();
    end

    // Drain, bounded
    set_idle();
    d_cdb = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
